wave_ram_ctrl: RTL and testbench
================================

// Module: wave_ram_ctrl
// PURPOSE
// - Channel-3 wave pattern RAM (16x8, FF30-FF3F) plus playback fetch/sample buffer.
// - Sits directly upstream of channel3: takes its wave_a/efar_q/atok and returns wave_play_d.
// - Also returns wave_ram_rd, the CPU-read strobe that channel3 muxes onto atok while idle.
// - Owns CPU read/write of wave RAM, including the redirect to the playing byte while ch3 runs.
// PARAMETERS
// - ADDR_BASE  16'hFF30  first byte address of wave RAM (16 bytes decoded)
// - HI_FIRST   1         1: efar_q=0 plays bits[7:4], efar_q=1 plays bits[3:0]; 0: swapped
// - RAM_INIT   8'h00     value loaded into every RAM byte on reset (sim determinism)
// PORTS
// - cery_2mhz    in     1   clock; all state updates on rising edge
// - napu_reset   in     1   asynchronous, active-low reset
// - a            in     16  CPU address
// - d            inout  8   CPU data bus; driven only during a decoded wave-RAM read, else 'z
// - ncpu_rd      in     1   CPU read strobe, active low, level
// - ncpu_wr      in     1   CPU write strobe, active low; a write commits on its falling edge
// - ch3_active   in     1   channel 3 playing
// - wave_a       in     4   byte index being played (from channel3)
// - efar_q       in     1   nibble select within the byte (from channel3)
// - atok         in     1   fetch clock from channel3; a fetch request is an atok 1->0 transition
// - wave_ram_rd  out    1   registered: CPU wave-RAM read in progress while ch3 inactive
// - wave_play_d  out    4   registered nibble presented to channel3's DAC path
// BEHAVIOUR
// - Reset (napu_reset=0, async):
//   - RAM bytes = RAM_INIT; sample_byte = 0; wave_play_d = 0; wave_ram_rd = 0.
//   - Edge-detect flops: atok_q = 1, nwr_q = 1; d = 'z.
// - Decode: hit = (a[15:4] == ADDR_BASE[15:4]).
//   - Effective index: idx = ch3_active ? wave_a : a[3:0].
// - Fetch pipeline, 2 cycles:
//   - C0: fall_det = atok_q & ~atok.
//   - C1: sample_byte <= ram[wave_a as sampled in C0]; then wave_play_d <= nibble(sample_byte, efar_q).
//   - wave_play_d is re-evaluated every cycle from sample_byte and efar_q.
//   - So an efar_q change is visible 1 cycle later, and a new byte 2 cycles after the atok fall.
// - CPU write:
//   - wr_fall = nwr_q & ~ncpu_wr & hit.
//   - On wr_fall, ram[idx] <= d, so while playing the write lands on the playing byte.
// - CPU read:
//   - d = ch3_active ? sample_byte : ram[a[3:0]] while hit & ~ncpu_rd; else 'z.
//   - wave_ram_rd <= hit & ~ncpu_rd & ~ch3_active.
// - Collision, fetch and write to the same byte in one cycle:
//   - Fetch returns the old byte (read-before-write) and the write commits.
//   - sample_byte takes the new value only on the next fetch.
// - Address wrap: wave_a 15 -> 0 needs no special case; the index is 4 bits.
// - ch3_active 1->0 mid-fetch:
//   - The in-flight fetch still completes into sample_byte.
//   - wave_play_d keeps updating; channel3 gates it with ch3_active.
// - Reset asserted mid-fetch: the fetch is abandoned; all state takes its reset values.
// - Out-of-range address (hit=0): no RAM access, d stays 'z, wave_ram_rd = 0.
// STRUCTURE
// - apu_pkg holds: WAVE_RAM_BASE, WAVE_RAM_DEPTH=16, typedef logic [3:0] wave_idx_t, typedef logic [3:0] nibble_t.
// - One sub-module, wave_ram_16x8:
//   - 1 write port, 2 async read ports (fetch, CPU).
//   - Async reset to RAM_INIT.
// - Top level keeps the edge detectors, decode, fetch pipeline, nibble mux and tri-state drivers.
// TESTING
// - Idle write/read:
//   - ch3_active=0; write FF35=8'hA7; read FF35.
//   - Expect d=8'hA7 and wave_ram_rd=1 one cycle after ncpu_rd falls.
// - Playback:
//   - Preload 16 bytes 8'h01..8'h10; ch3_active=1; step wave_a 0..15 with an atok fall per byte; toggle efar_q.
//   - Expect wave_play_d = 0,1,0,2,... 2 cycles after each fall.
// - Redirect:
//   - ch3_active=1, wave_a=7, write FF32=8'h5C.
//   - Expect ram[7]=8'h5C, ram[2] unchanged, and a CPU read returns sample_byte.
// - Collision:
//   - atok fall and CPU write 8'hFF on the same cycle to byte 3, which holds 8'h12.
//   - Expect sample_byte=8'h12 and ram[3]=8'hFF; the next fetch of byte 3 gives 8'hFF.
// - Reset mid-fetch:
//   - Pull napu_reset low 1 cycle after an atok fall.
//   - Expect wave_play_d=0, sample_byte=0, all RAM bytes = RAM_INIT, and d='z.
// - Decode edges:
//   - Access FF2F and FF40.
//   - Expect no RAM change, d='z, and wave_ram_rd=0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU types and constants for the channel-3 wave RAM path.
// Holds the wave RAM address window and the nibble-select helper.
package apu_pkg;

    localparam logic [15:0] WAVE_RAM_BASE  = 16'hFF30;
    localparam int          WAVE_RAM_DEPTH = 16;

    typedef logic [3:0] wave_idx_t;
    typedef logic [3:0] nibble_t;

    // hi_first=1: efar=0 picks the high nibble; hi_first=0 reverses the order
    function automatic nibble_t sel_nibble(input logic [7:0] b, input logic efar, input logic hi_first);
        return (efar == hi_first) ? b[3:0] : b[7:4];
    endfunction

endpackage

// File: rtl/wave_ram_ctrl_if.sv
// CPU bus and channel-3 playback signals shared between wave_ram_ctrl and its neighbours.
// The tri-state data bus stays a plain inout on the top module.
interface wave_ram_ctrl_if;
    import apu_pkg::*;

    logic [15:0] a;
    logic        ncpu_rd;
    logic        ncpu_wr;
    logic        ch3_active;
    wave_idx_t   wave_a;
    logic        efar_q;
    logic        atok;
    logic        wave_ram_rd;
    nibble_t     wave_play_d;

    modport master (
        output a, ncpu_rd, ncpu_wr, ch3_active, wave_a, efar_q, atok,
        input  wave_ram_rd, wave_play_d
    );

    modport slave (
        input  a, ncpu_rd, ncpu_wr, ch3_active, wave_a, efar_q, atok,
        output wave_ram_rd, wave_play_d
    );

endinterface

// File: rtl/wave_ram_ctrl_ram.sv
// 16x8 wave pattern storage: one synchronous write port, two asynchronous read ports.
// Reads see the pre-write contents within a cycle, which gives read-before-write on collision.
module wave_ram_16x8
    import apu_pkg::*;
#(
    parameter logic [7:0] RAM_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  wave_idx_t  waddr,
    input  logic [7:0] wdata,
    input  wave_idx_t  faddr,
    output logic [7:0] fdata,
    input  wave_idx_t  caddr,
    output logic [7:0] cdata
);

    logic [7:0] mem_r [WAVE_RAM_DEPTH];

    // Storage array with reset to a known pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WAVE_RAM_DEPTH; i++) begin
                mem_r[i] <= RAM_INIT;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign fdata = mem_r[faddr];
    assign cdata = mem_r[caddr];

endmodule

// File: rtl/wave_ram_ctrl.sv
// Channel-3 wave RAM controller: CPU access window, atok-driven byte fetch and nibble output.
// While channel 3 plays, CPU accesses are redirected to the byte being played.
module wave_ram_ctrl
    import apu_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE = WAVE_RAM_BASE,
    parameter logic        HI_FIRST  = 1'b1,
    parameter logic [7:0]  RAM_INIT  = 8'h00
) (
    input  logic            cery_2mhz,
    input  logic            napu_reset,
    inout  wire  [7:0]      d,
    wave_ram_ctrl_if.slave  bus
);

    logic       atok_q_r;
    logic       nwr_q_r;
    logic [7:0] sample_byte_r;
    nibble_t    play_r;
    logic       ram_rd_r;

    logic       hit_s;
    logic       fall_det_s;
    logic       wr_fall_s;
    logic       drive_s;
    wave_idx_t  idx_s;
    logic [7:0] fetch_data_s;
    logic [7:0] cpu_data_s;
    logic [7:0] rd_data_s;

    assign hit_s      = (bus.a[15:4] == ADDR_BASE[15:4]);
    assign idx_s      = bus.ch3_active ? bus.wave_a : bus.a[3:0];
    assign fall_det_s = atok_q_r & ~bus.atok;
    assign wr_fall_s  = nwr_q_r & ~bus.ncpu_wr & hit_s;

    wave_ram_16x8 #(
        .RAM_INIT (RAM_INIT)
    ) u_ram (
        .clk   (cery_2mhz),
        .rst_n (napu_reset),
        .we    (wr_fall_s),
        .waddr (idx_s),
        .wdata (d),
        .faddr (bus.wave_a),
        .fdata (fetch_data_s),
        .caddr (bus.a[3:0]),
        .cdata (cpu_data_s)
    );

    // Edge detectors for the fetch clock and the CPU write strobe
    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            atok_q_r <= 1'b1;
            nwr_q_r  <= 1'b1;
        end else begin
            atok_q_r <= bus.atok;
            nwr_q_r  <= bus.ncpu_wr;
        end
    end

    // Fetch pipeline: byte capture on atok fall, nibble select every cycle
    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            sample_byte_r <= 8'h00;
            play_r        <= 4'h0;
            ram_rd_r      <= 1'b0;
        end else begin
            if (fall_det_s) begin
                sample_byte_r <= fetch_data_s;
            end
            play_r   <= sel_nibble(sample_byte_r, bus.efar_q, HI_FIRST);
            ram_rd_r <= hit_s & ~bus.ncpu_rd & ~bus.ch3_active;
        end
    end

    // During playback the CPU only ever sees the latched sample byte
    assign rd_data_s = bus.ch3_active ? sample_byte_r : cpu_data_s;
    assign drive_s   = hit_s & ~bus.ncpu_rd & napu_reset;
    assign d         = drive_s ? rd_data_s : 8'hzz;

    assign bus.wave_play_d = play_r;
    assign bus.wave_ram_rd = ram_rd_r;

endmodule

// File: tb/tb_wave_ram_ctrl.sv
// Directed bench for wave_ram_ctrl: a behavioural RAM/playback model checked every cycle,
// plus literal expectations for the idle, playback, redirect, collision, reset and decode cases.
module tb_wave_ram_ctrl;
    import apu_pkg::*;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       drv_en = 1'b0;
    logic [7:0] d_drv  = 8'h00;
    wire  [7:0] d;

    int checks   = 0;
    int failures = 0;

    logic       lit_valid    = 1'b0;
    logic       lit_use_d    = 1'b0;
    logic       lit_use_rd   = 1'b0;
    logic       lit_use_play = 1'b0;
    logic [7:0] lit_d        = 8'h00;
    logic       lit_rd       = 1'b0;
    logic [3:0] lit_play     = 4'h0;
    string      lit_name     = "";

    logic [7:0] m_mem [16];
    logic [7:0] m_sample;
    logic [3:0] m_play;
    logic       m_rd;
    logic       m_atok_q;
    logic       m_nwr_q;

    wave_ram_ctrl_if bus();

    assign d = drv_en ? d_drv : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (d[i]);
    end

    always #5 clk = ~clk;

    wave_ram_ctrl #(
        .ADDR_BASE (16'hFF30),
        .HI_FIRST  (1'b1),
        .RAM_INIT  (8'h00)
    ) dut (
        .cery_2mhz  (clk),
        .napu_reset (rst_n),
        .d          (d),
        .bus        (bus)
    );

    function automatic logic in_win(input logic [15:0] addr);
        return (addr >= 16'hFF30) && (addr <= 16'hFF3F);
    endfunction

    function automatic logic [3:0] off4(input logic [15:0] addr);
        logic [15:0] o;
        o = addr - 16'hFF30;
        return o[3:0];
    endfunction

    // First played nibble of a byte is its upper digit in base 16
    function automatic logic [3:0] pick(input logic [7:0] b, input logic e);
        logic [7:0] t;
        t = e ? (b % 8'd16) : (b / 8'd16);
        return t[3:0];
    endfunction

    // Behavioural model of RAM contents, latched sample, played nibble and read strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= 8'h00;
            m_sample <= 8'h00;
            m_play   <= 4'h0;
            m_rd     <= 1'b0;
            m_atok_q <= 1'b1;
            m_nwr_q  <= 1'b1;
        end else begin
            m_atok_q <= bus.atok;
            m_nwr_q  <= bus.ncpu_wr;
            m_play   <= pick(m_sample, bus.efar_q);
            m_rd     <= in_win(bus.a) && !bus.ncpu_rd && !bus.ch3_active;
            if (m_atok_q && !bus.atok) m_sample <= m_mem[bus.wave_a];
            if (m_nwr_q && !bus.ncpu_wr && in_win(bus.a)) begin
                if (bus.ch3_active) m_mem[bus.wave_a] <= d_drv;
                else                m_mem[off4(bus.a)] <= d_drv;
            end
        end
    end

    // Per-cycle comparison against the model, plus any pending literal expectation
    always begin
        logic [7:0] ed;
        @(negedge clk);
        checks++;
        if (bus.wave_play_d !== m_play) begin
            failures++;
            $display("FAIL model_play t=%0t got=%h want=%h", $time, bus.wave_play_d, m_play);
        end
        checks++;
        if (bus.wave_ram_rd !== m_rd) begin
            failures++;
            $display("FAIL model_rd t=%0t got=%b want=%b", $time, bus.wave_ram_rd, m_rd);
        end
        if (!drv_en) begin
            if (rst_n && in_win(bus.a) && !bus.ncpu_rd)
                ed = bus.ch3_active ? m_sample : m_mem[off4(bus.a)];
            else
                ed = 8'hFF;
            checks++;
            if (d !== ed) begin
                failures++;
                $display("FAIL model_d t=%0t got=%h want=%h", $time, d, ed);
            end
        end
        if (lit_valid) begin
            if (lit_use_d) begin
                checks++;
                if (d !== lit_d) begin
                    failures++;
                    $display("FAIL %s d got=%h want=%h", lit_name, d, lit_d);
                end
            end
            if (lit_use_rd) begin
                checks++;
                if (bus.wave_ram_rd !== lit_rd) begin
                    failures++;
                    $display("FAIL %s wave_ram_rd got=%b want=%b", lit_name, bus.wave_ram_rd, lit_rd);
                end
            end
            if (lit_use_play) begin
                checks++;
                if (bus.wave_play_d !== lit_play) begin
                    failures++;
                    $display("FAIL %s wave_play_d got=%h want=%h", lit_name, bus.wave_play_d, lit_play);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_lit(input string nm, input logic ud, input logic [7:0] vd,
                              input logic ur, input logic vr, input logic up, input logic [3:0] vp);
        lit_name = nm; lit_use_d = ud; lit_d = vd;
        lit_use_rd = ur; lit_rd = vr; lit_use_play = up; lit_play = vp;
        lit_valid = 1'b1;
        step();
        lit_valid = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] val);
        bus.a = addr; d_drv = val; drv_en = 1'b1; bus.ncpu_wr = 1'b0;
        step();
        bus.ncpu_wr = 1'b1; drv_en = 1'b0;
        step();
    endtask

    task automatic rd_check(input string nm, input logic [15:0] addr, input logic [7:0] vd, input logic vr);
        bus.a = addr; bus.ncpu_rd = 1'b0;
        expect_lit(nm, 1'b1, vd, 1'b1, vr, 1'b0, 4'h0);
        bus.ncpu_rd = 1'b1;
        step();
    endtask

    initial begin
        bus.a = 16'h0000; bus.ncpu_rd = 1'b1; bus.ncpu_wr = 1'b1;
        bus.ch3_active = 1'b0; bus.wave_a = 4'h0; bus.efar_q = 1'b0; bus.atok = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        expect_lit("reset_state", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 4'h0);

        wr(16'hFF35, 8'hA7);
        rd_check("idle_rd", 16'hFF35, 8'hA7, 1'b1);

        for (int i = 0; i < 16; i++) wr(16'hFF30 + 16'(i), 8'(i + 1));
        bus.ch3_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wave_a = 4'(i); bus.atok = 1'b0; bus.efar_q = 1'b0;
            step();
            bus.atok = 1'b1;
            expect_lit("play_hi", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'((i + 1) / 16));
            bus.efar_q = 1'b1;
            expect_lit("play_lo", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'((i + 1) % 16));
        end

        bus.wave_a = 4'd7;
        wr(16'hFF32, 8'h5C);
        rd_check("redir_sample", 16'hFF32, 8'h10, 1'b0);
        bus.ch3_active = 1'b0;
        rd_check("redir_ram7", 16'hFF37, 8'h5C, 1'b1);
        rd_check("redir_ram2", 16'hFF32, 8'h03, 1'b1);

        wr(16'hFF33, 8'h12);
        bus.ch3_active = 1'b1; bus.wave_a = 4'd3;
        bus.atok = 1'b0; bus.a = 16'hFF33; d_drv = 8'hFF; drv_en = 1'b1; bus.ncpu_wr = 1'b0;
        step();
        bus.ncpu_wr = 1'b1; drv_en = 1'b0; bus.atok = 1'b1; bus.efar_q = 1'b0;
        expect_lit("coll_old_hi", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h1);
        bus.efar_q = 1'b1;
        expect_lit("coll_old_lo", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h2);
        rd_check("coll_sample", 16'hFF30, 8'h12, 1'b0);
        bus.atok = 1'b0;
        step();
        bus.atok = 1'b1; bus.efar_q = 1'b0;
        expect_lit("coll_new_hi", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'hF);
        bus.ch3_active = 1'b0;
        rd_check("coll_ram3", 16'hFF33, 8'hFF, 1'b1);

        bus.ch3_active = 1'b1; bus.wave_a = 4'd5; bus.atok = 1'b0;
        step();
        bus.atok = 1'b1; rst_n = 1'b0;
        bus.ch3_active = 1'b0; bus.a = 16'hFF35; bus.ncpu_rd = 1'b0;
        expect_lit("rst_mid", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 4'h0);
        bus.ncpu_rd = 1'b1; rst_n = 1'b1;
        step();
        rd_check("rst_ram5", 16'hFF35, 8'h00, 1'b1);
        bus.ch3_active = 1'b1;
        rd_check("rst_sample", 16'hFF30, 8'h00, 1'b0);
        expect_lit("rst_play", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0);
        bus.ch3_active = 1'b0;

        wr(16'hFF30, 8'h21);
        wr(16'hFF3F, 8'h3C);
        wr(16'hFF2F, 8'h77);
        wr(16'hFF40, 8'h88);
        rd_check("dec_ff2f", 16'hFF2F, 8'hFF, 1'b0);
        rd_check("dec_ff40", 16'hFF40, 8'hFF, 1'b0);
        rd_check("dec_ram0", 16'hFF30, 8'h21, 1'b1);
        rd_check("dec_ram15", 16'hFF3F, 8'h3C, 1'b1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
